// File: rtl/modbus_rsp_tx_ctrl.sv
// Modbus RTU read-response sequencer: starts tx_crc, shares DPRAM port B with it,
// then streams address, function, byte count, register words and CRC to the UART.
module modbus_rsp_tx_ctrl #(
   parameter logic [7:0]  SADDR   = 8'h01,
   parameter logic [7:0]  MAX_QTY = 8'd125,
   parameter int unsigned A_WIDTH = 8
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               rsp_start,
   input  logic [7:0]         func_code,
   input  logic [7:0]         quantity,
   output logic               crc_start,
   input  logic [A_WIDTH-1:0] crc_addr,
   input  logic [15:0]        crc_calc,
   input  logic               crc_done,
   output logic [A_WIDTH-1:0] ram_addr,
   input  logic [15:0]        ram_data,
   output logic [7:0]         tx_byte,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic               rsp_done,
   output logic               rsp_err
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CRC_REQ,
      S_CRC_WAIT,
      S_HDR0,
      S_HDR1,
      S_HDR2,
      S_RD,
      S_DHI,
      S_DLO,
      S_CLO,
      S_CHI,
      S_DONE
   } state_t;

   state_t      state_reg, state_next;
   logic [7:0]  func_reg, func_next;
   logic [7:0]  qty_reg, qty_next;
   logic [15:0] crc_reg, crc_next;
   logic [15:0] word_reg, word_next;
   logic [7:0]  rd_idx_reg, rd_idx_next;
   logic        rd_wait_reg, rd_wait_next;
   logic        rsp_err_reg, rsp_err_next;
   logic        qty_legal;

   assign qty_legal = (quantity != 8'd0) && (quantity <= MAX_QTY);
   assign rsp_err   = rsp_err_reg;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_reg   <= S_IDLE;
         func_reg    <= 8'd0;
         qty_reg     <= 8'd0;
         crc_reg     <= 16'd0;
         word_reg    <= 16'd0;
         rd_idx_reg  <= 8'd0;
         rd_wait_reg <= 1'b0;
         rsp_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         func_reg    <= func_next;
         qty_reg     <= qty_next;
         crc_reg     <= crc_next;
         word_reg    <= word_next;
         rd_idx_reg  <= rd_idx_next;
         rd_wait_reg <= rd_wait_next;
         rsp_err_reg <= rsp_err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      func_next    = func_reg;
      qty_next     = qty_reg;
      crc_next     = crc_reg;
      word_next    = word_reg;
      rd_idx_next  = rd_idx_reg;
      rd_wait_next = rd_wait_reg;
      rsp_err_next = 1'b0;
      crc_start    = 1'b0;
      tx_valid     = 1'b0;
      tx_byte      = 8'd0;
      busy         = 1'b1;
      rsp_done     = 1'b0;
      // Port B belongs to tx_crc only while its CRC pass is running.
      ram_addr     = A_WIDTH'(rd_idx_reg);

      case (state_reg)
         S_IDLE: begin
            busy = 1'b0;
            if (rsp_start) begin
               if (qty_legal) begin
                  func_next    = func_code;
                  qty_next     = quantity;
                  rd_idx_next  = 8'd0;
                  rd_wait_next = 1'b0;
                  state_next   = S_CRC_REQ;
               end else begin
                  rsp_err_next = 1'b1;
               end
            end
         end
         S_CRC_REQ: begin
            crc_start  = 1'b1;
            ram_addr   = crc_addr;
            state_next = S_CRC_WAIT;
         end
         S_CRC_WAIT: begin
            ram_addr = crc_addr;
            if (crc_done) begin
               crc_next   = crc_calc;
               state_next = S_HDR0;
            end
         end
         S_HDR0: begin
            tx_valid = 1'b1;
            tx_byte  = SADDR;
            if (tx_ready) state_next = S_HDR1;
         end
         S_HDR1: begin
            tx_valid = 1'b1;
            tx_byte  = func_reg;
            if (tx_ready) state_next = S_HDR2;
         end
         S_HDR2: begin
            tx_valid = 1'b1;
            tx_byte  = {qty_reg[6:0], 1'b0};
            if (tx_ready) begin
               rd_wait_next = 1'b0;
               state_next   = S_RD;
            end
         end
         S_RD: begin
            // First cycle presents the address; the word is valid on the second.
            if (!rd_wait_reg) begin
               rd_wait_next = 1'b1;
            end else begin
               word_next    = ram_data;
               rd_wait_next = 1'b0;
               state_next   = S_DHI;
            end
         end
         S_DHI: begin
            tx_valid = 1'b1;
            tx_byte  = word_reg[15:8];
            if (tx_ready) state_next = S_DLO;
         end
         S_DLO: begin
            tx_valid = 1'b1;
            tx_byte  = word_reg[7:0];
            if (tx_ready) begin
               if (rd_idx_reg + 8'd1 == qty_reg) begin
                  state_next = S_CLO;
               end else begin
                  rd_idx_next = rd_idx_reg + 8'd1;
                  state_next  = S_RD;
               end
            end
         end
         S_CLO: begin
            tx_valid = 1'b1;
            tx_byte  = crc_reg[7:0];
            if (tx_ready) state_next = S_CHI;
         end
         S_CHI: begin
            tx_valid = 1'b1;
            tx_byte  = crc_reg[15:8];
            if (tx_ready) state_next = S_DONE;
         end
         S_DONE: begin
            busy       = 1'b0;
            rsp_done   = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_modbus_rsp_tx_ctrl.sv
// Directed bench for modbus_rsp_tx_ctrl with DPRAM and tx_crc models and a UART sink.
module tb_modbus_rsp_tx_ctrl;

   logic        clk_in;
   logic        rst_n_in;
   logic        rsp_start;
   logic [7:0]  func_code;
   logic [7:0]  quantity;
   logic        crc_start;
   logic [7:0]  crc_addr;
   logic [15:0] crc_calc;
   logic        crc_done;
   logic [7:0]  ram_addr;
   logic [15:0] ram_data;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        rsp_done;
   logic        rsp_err;

   modbus_rsp_tx_ctrl dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rsp_start(rsp_start),
      .func_code(func_code),
      .quantity (quantity),
      .crc_start(crc_start),
      .crc_addr (crc_addr),
      .crc_calc (crc_calc),
      .crc_done (crc_done),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .tx_byte  (tx_byte),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .rsp_done (rsp_done),
      .rsp_err  (rsp_err)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:255];
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   logic [15:0] crc_model = 16'd0;
   logic        crc_active = 1'b0;

   // monitor-owned counters (cumulative; main flow works on deltas)
   int cs_cnt = 0, dn_cnt = 0, er_cnt = 0, tv_cnt = 0, ab_cnt = 0;
   int stall_chk = 0, stall_bad = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_byte = 8'd0;

   always @(posedge clk_in) ram_data <= mem[ram_addr];

   // tx_crc stand-in: walks crc_addr, answers after a few cycles
   int crc_cnt = 0;
   initial begin
      crc_addr = 8'h5A;
      crc_done = 1'b0;
      crc_calc = 16'hDEAD;
   end
   always begin
      @(posedge clk_in);
      #2;
      crc_done = 1'b0;
      crc_calc = 16'hDEAD;
      if (crc_start) begin
         crc_active = 1'b1;
         crc_cnt    = 4;
         crc_addr   = 8'hA0;
      end else if (crc_active) begin
         crc_addr = crc_addr + 8'd1;
         if (crc_cnt == 0) begin
            crc_done   = 1'b1;
            crc_calc   = crc_model;
            crc_active = 1'b0;
         end else begin
            crc_cnt = crc_cnt - 1;
         end
      end
   end

   always @(negedge clk_in) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_byte);
      if (prev_stall) begin
         stall_chk = stall_chk + 1;
         if (!(tx_valid && tx_byte == prev_byte)) stall_bad = stall_bad + 1;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      if (crc_start) cs_cnt = cs_cnt + 1;
      if (rsp_done)  dn_cnt = dn_cnt + 1;
      if (rsp_err)   er_cnt = er_cnt + 1;
      if (tx_valid)  tv_cnt = tv_cnt + 1;
      if ((crc_start || crc_active || crc_done) && ram_addr !== crc_addr) ab_cnt = ab_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, "_tx_valid"}, tx_valid, 1'b0);
      chk({tag, "_tx_byte"}, tx_byte, 8'h00);
      chk({tag, "_crc_start"}, crc_start, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_rsp_done"}, rsp_done, 1'b0);
      chk({tag, "_rsp_err"}, rsp_err, 1'b0);
      chk({tag, "_ram_addr"}, ram_addr, 8'h00);
   endtask

   // mode 0: ready high; 1: 20-cycle stall then random ready; 2: re-pulse rsp_start
   task automatic run_frame(input logic [7:0] f, input logic [7:0] q, input int mode,
                            input int abort_at);
      int base, cs0, dn0, er0, sb0, sc0, ab0, n, got, stall_left, busy_bad;
      logic stall_used, rep1, rep2, aborted;
      logic [15:0] crc, rxb;
      exp_q.delete();
      exp_q.push_back(8'h01);
      exp_q.push_back(f);
      exp_q.push_back({q[6:0], 1'b0});
      for (int i = 0; i < int'(q); i++) begin
         exp_q.push_back(mem[i][15:8]);
         exp_q.push_back(mem[i][7:0]);
      end
      crc = 16'hFFFF;
      foreach (exp_q[i]) begin
         crc = crc ^ {8'h00, exp_q[i]};
         for (int b = 0; b < 8; b++)
            crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
      end
      crc_model = crc;
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);

      base = rx_q.size();
      cs0 = cs_cnt; dn0 = dn_cnt; er0 = er_cnt; sb0 = stall_bad; sc0 = stall_chk; ab0 = ab_cnt;
      func_code = f; quantity = q; rsp_start = 1'b1; tx_ready = 1'b1;
      cyc();
      rsp_start = 1'b0; func_code = 8'hEE; quantity = 8'd3;
      n = 0; stall_left = 0; busy_bad = 0;
      stall_used = 1'b0; rep1 = 1'b0; rep2 = 1'b0; aborted = 1'b0;
      while (dn_cnt == dn0 && n < 4000) begin
         got = rx_q.size() - base;
         if (abort_at > 0 && got >= abort_at) begin
            aborted = 1'b1;
            break;
         end
         if (!busy && !rsp_done) busy_bad++;
         tx_ready = 1'b1;
         rsp_start = 1'b0;
         if (mode == 1) begin
            if (!stall_used && got == 5 && tx_valid) begin
               stall_left = 20;
               stall_used = 1'b1;
            end
            if (stall_left > 0) begin
               tx_ready = 1'b0;
               stall_left--;
            end else begin
               tx_ready = 1'($urandom_range(0, 1));
            end
         end else if (mode == 2) begin
            if (crc_active && !rep1) begin
               rsp_start = 1'b1; rep1 = 1'b1;
            end else if (tx_valid && got == 3 && !rep2) begin
               rsp_start = 1'b1; rep2 = 1'b1;
            end
         end
         cyc();
         n++;
      end
      rsp_start = 1'b0;
      tx_ready  = 1'b0;

      if (aborted) begin
         rst_n_in = 1'b0;
         cyc();
         idle_outputs("abort");
         rst_n_in = 1'b1;
         repeat (4) cyc();
         chk("abort_no_done", dn_cnt - dn0, 0);
         chk("abort_idle_busy", busy, 1'b0);
         $display("frame func=%02h qty=%0d aborted after %0d bytes", f, q, rx_q.size() - base);
         return;
      end

      got = rx_q.size() - base;
      $display("frame func=%02h qty=%0d mode=%0d bytes=%0d crc=%04h", f, q, mode, got, crc);
      chk("frame_len", got, exp_q.size());
      foreach (exp_q[i]) begin
         rxb = (base + i < rx_q.size()) ? {8'h00, rx_q[base + i]} : 16'hFFFF;
         chk($sformatf("byte%0d", i), rxb, {8'h00, exp_q[i]});
      end
      chk("crc_start_cnt", cs_cnt - cs0, 1);
      chk("rsp_done_cnt", dn_cnt - dn0, 1);
      chk("rsp_err_cnt", er_cnt - er0, 0);
      chk("stall_stable", stall_bad - sb0, 0);
      chk("crc_addr_mux", ab_cnt - ab0, 0);
      chk("busy_gap", busy_bad, 0);
      cyc();
      chk("busy_after", busy, 1'b0);
      chk("done_after", rsp_done, 1'b0);
      if (mode == 1) chk("stall_seen", (stall_chk - sc0) >= 20, 1'b1);
   endtask

   task automatic bad_qty(input logic [7:0] q);
      int er0, cs0, tv0;
      er0 = er_cnt; cs0 = cs_cnt; tv0 = tv_cnt;
      func_code = 8'h04; quantity = q; rsp_start = 1'b1; tx_ready = 1'b1;
      cyc();
      rsp_start = 1'b0;
      chk($sformatf("err_pulse_q%0d", q), rsp_err, 1'b1);
      chk($sformatf("err_busy_q%0d", q), busy, 1'b0);
      cyc();
      chk($sformatf("err_clear_q%0d", q), rsp_err, 1'b0);
      repeat (6) cyc();
      chk($sformatf("err_cnt_q%0d", q), er_cnt - er0, 1);
      chk($sformatf("err_no_crc_q%0d", q), cs_cnt - cs0, 0);
      chk($sformatf("err_no_tx_q%0d", q), tv_cnt - tv0, 0);
      tx_ready = 1'b0;
      $display("reject qty=%0d rsp_err=%0d", q, er_cnt - er0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h3C5A;
      mem[0] = 16'h1235; mem[1] = 16'h2351; mem[2] = 16'h3516; mem[3] = 16'hAAAA;
      mem[4] = 16'h5555; mem[5] = 16'h7654; mem[6] = 16'h4567; mem[7] = 16'h9776;
      mem[8] = 16'h1235; mem[9] = 16'h4782;
      rst_n_in = 1'b0; rsp_start = 1'b0; func_code = 8'h00; quantity = 8'h00; tx_ready = 1'b0;
      repeat (3) cyc();
      idle_outputs("reset");
      rst_n_in = 1'b1;
      repeat (2) cyc();

      run_frame(8'h04, 8'd2, 0, 0);
      chk("t1_hdr0", rx_q[0], 8'h01);
      chk("t1_bytecnt", rx_q[2], 8'h04);
      chk("t1_d0hi", rx_q[3], 8'h12);
      chk("t1_d1lo", rx_q[6], 8'h51);
      run_frame(8'h04, 8'd10, 0, 0);
      run_frame(8'h04, 8'd2, 1, 0);
      bad_qty(8'd0);
      bad_qty(8'd126);
      run_frame(8'h03, 8'd1, 0, 0);
      run_frame(8'h04, 8'd125, 0, 0);
      run_frame(8'h04, 8'd10, 2, 0);
      run_frame(8'h04, 8'd10, 0, 8);
      run_frame(8'h04, 8'd2, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
